// File: rtl/sclk_word_tx.sv
// Serial word transmitter: shifts DATA_W-bit words out MSB-first on SDATA with a divided SCLK
// strobe, and keeps a wrapping count of the SCLK falling edges it has generated.
module sclk_word_tx #(
    parameter int unsigned DIV_HALF = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned GAP_CYC  = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              SCLK,
    output logic              SDATA,
    output logic              BUSY,
    output logic              WORD_DONE,
    output logic [7:0]        EDGE_CNT
);

    // One counter serves both the half-period divider and the inter-word gap.
    localparam int unsigned CntMax = (DIV_HALF > GAP_CYC) ? DIV_HALF : GAP_CYC;
    localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax + 1);
    localparam int unsigned BitsW  = $clog2(DATA_W + 1);

    localparam logic [CntW-1:0]  DivLast = CntW'(DIV_HALF - 1);
    localparam logic [CntW-1:0]  GapLast = CntW'(GAP_CYC - 1);
    localparam logic [CntW-1:0]  CntOne  = CntW'(1);
    localparam logic [BitsW-1:0] BitsOne = BitsW'(1);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StGap} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [BitsW-1:0]    bits_q, bits_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                sclk_q, sclk_d;
    logic                sdata_q, sdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [7:0]          edge_q, edge_d;

    assign DIN_READY = (state_q == StIdle) & RST_N;
    assign SCLK      = sclk_q;
    assign SDATA     = sdata_q;
    assign BUSY      = busy_q;
    assign WORD_DONE = done_q;
    assign EDGE_CNT  = edge_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bits_q  <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b1;
            sdata_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            edge_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            edge_q  <= edge_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        sdata_d = sdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        edge_d  = edge_q;

        unique case (state_q)
            StIdle: begin
                sclk_d  = 1'b1;
                sdata_d = 1'b0;
                if (DIN_VALID && DIN_READY) begin
                    shreg_d = DIN;
                    bits_d  = BitsW'(DATA_W);
                    sclk_d  = 1'b0;
                    sdata_d = DIN[DATA_W-1];
                    edge_d  = edge_q + 8'd1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StLow;
                end
            end
            StLow: begin
                if (cnt_q == DivLast) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = StHigh;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StHigh: begin
                if (cnt_q == DivLast) begin
                    cnt_d  = '0;
                    bits_d = bits_q - BitsOne;
                    if (bits_q > BitsOne) begin
                        // Bit already on SDATA sits at the MSB; the next one is just below it.
                        shreg_d = shreg_q << 1;
                        sdata_d = shreg_q[DATA_W-2];
                        sclk_d  = 1'b0;
                        edge_d  = edge_q + 8'd1;
                        state_d = StLow;
                    end else begin
                        done_d  = 1'b1;
                        sdata_d = 1'b0;
                        if (GAP_CYC == 0) begin
                            busy_d  = 1'b0;
                            state_d = StIdle;
                        end else begin
                            state_d = StGap;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StGap: begin
                sclk_d = 1'b1;
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_sclk_word_tx.sv
// Self-checking bench for sclk_word_tx: default-parameter instance plus a fast
// DIV_HALF=1 / GAP_CYC=0 instance; serial words are checked through a scoreboard queue.
module tb_sclk_word_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready, sclk, sdata, busy, word_done;
    logic [7:0] edge_cnt;

    logic       rst6;
    logic [7:0] din6;
    logic       valid6;
    logic       ready6, sclk6, sdata6, busy6, done6;
    logic [7:0] edge6;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] sb_q[$];
    int         done_cnt = 0;
    logic [7:0] mon_word = 8'd0;
    int         mon_bits = 0;
    logic       sclk_prev = 1'b1;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_edge;
        logic       exp_msb;
    } vec_t;

    vec_t tbl [32];

    sclk_word_tx dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .DIN       (din),
        .DIN_VALID (din_valid),
        .DIN_READY (din_ready),
        .SCLK      (sclk),
        .SDATA     (sdata),
        .BUSY      (busy),
        .WORD_DONE (word_done),
        .EDGE_CNT  (edge_cnt)
    );

    sclk_word_tx #(
        .DIV_HALF (1),
        .DATA_W   (8),
        .GAP_CYC  (0)
    ) dut6 (
        .CLK       (clk),
        .RST_N     (rst6),
        .DIN       (din6),
        .DIN_VALID (valid6),
        .DIN_READY (ready6),
        .SCLK      (sclk6),
        .SDATA     (sdata6),
        .BUSY      (busy6),
        .WORD_DONE (done6),
        .EDGE_CNT  (edge6)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serial monitor: assemble SDATA at each SCLK rise, compare whole words on WORD_DONE.
    always @(negedge clk) begin
        logic [7:0] exp_w;
        if (rst_n && busy && sclk && !sclk_prev) begin
            mon_word = {mon_word[6:0], sdata};
            mon_bits++;
        end
        if (word_done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                timeout("sb_unexpected_word");
            end else begin
                exp_w = sb_q.pop_front();
                check("serial_word", {24'd0, mon_word}, {24'd0, exp_w});
                check("serial_bits", mon_bits, 8);
            end
            mon_bits = 0;
        end
        if (!rst_n) mon_bits = 0;
        sclk_prev = sclk;
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        #1;
    endtask

    // Offer a word and return just after the edge that accepts it.
    task automatic send_start(input logic [7:0] w, input bit keep_valid);
        int n;
        din       = w;
        din_valid = 1'b1;
        sb_q.push_back(w);
        n = 0;
        while (!din_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) timeout("send_ready");
        tick(1);
        if (!keep_valid) din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!din_ready && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) timeout("wait_idle");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         d0, k;
        logic [7:0] w6;

        rst_n = 1'b0; din = 8'd0; din_valid = 1'b0;
        rst6 = 1'b0; din6 = 8'd0; valid6 = 1'b0;

        for (int i = 0; i < 32; i++) begin
            tbl[i].din      = 8'(i * 37 + 11);
            tbl[i].exp_edge = 8'((i + 1) * 8);
            tbl[i].exp_msb  = tbl[i].din[7];
        end

        // Reset state
        tick(3);
        check("rst_ready", din_ready, 0);
        check("rst_sclk", sclk, 1);
        check("rst_sdata", sdata, 0);
        check("rst_edge", edge_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", word_done, 0);
        rst_n = 1'b1;
        #1;
        check("rel_ready", din_ready, 1);
        tick(1);
        check("rel_ready_next", din_ready, 1);
        check("rel_sclk", sclk, 1);

        // Single word 0xA5 with cycle-exact timing
        send_start(8'hA5, 0);
        check("a5_c0_sclk", sclk, 0);
        check("a5_c0_sdata", sdata, 1);
        check("a5_c0_busy", busy, 1);
        check("a5_c0_edge", edge_cnt, 1);
        check("a5_c0_ready", din_ready, 0);
        tick(3);
        check("a5_c3_sclk", sclk, 0);
        tick(1);
        check("a5_c4_sclk", sclk, 1);
        tick(4);
        check("a5_c8_sclk", sclk, 0);
        check("a5_c8_sdata", sdata, 0);
        check("a5_c8_edge", edge_cnt, 2);
        tick(55);
        check("a5_c63_done", word_done, 0);
        tick(1);
        check("a5_c64_done", word_done, 1);
        check("a5_c64_sdata", sdata, 0);
        check("a5_c64_sclk", sclk, 1);
        tick(1);
        check("a5_c65_done", word_done, 0);
        check("a5_c65_ready", din_ready, 0);
        check("a5_c65_busy", busy, 1);
        tick(1);
        check("a5_c66_ready", din_ready, 1);
        check("a5_c66_busy", busy, 0);
        check("a5_c66_edge", edge_cnt, 8);

        // Back-to-back 0x00 then 0xFF with DIN_VALID held
        apply_reset();
        d0 = done_cnt;
        send_start(8'h00, 1);
        din = 8'hFF;
        sb_q.push_back(8'hFF);
        k = 0;
        while (!din_ready && k < 200) begin
            tick(1);
            k++;
        end
        check("b2b_ready_cycle", k, 66);
        tick(1);
        din_valid = 1'b0;
        check("b2b_2nd_sclk", sclk, 0);
        check("b2b_2nd_sdata", sdata, 1);
        check("b2b_2nd_edge", edge_cnt, 9);
        wait_idle();
        check("b2b_edge", edge_cnt, 16);
        check("b2b_dones", done_cnt - d0, 2);

        // EDGE_CNT wrap over 32 words
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            send_start(tbl[i].din, 0);
            check($sformatf("tbl%0d_msb", i), sdata, tbl[i].exp_msb);
            wait_idle();
            check($sformatf("tbl%0d_edge", i), edge_cnt, tbl[i].exp_edge);
        end

        // Reset mid-word after the third falling edge
        apply_reset();
        d0 = done_cnt;
        send_start(8'hA5, 0);
        k = 0;
        while (edge_cnt != 8'd3 && k < 100) begin
            tick(1);
            k++;
        end
        if (k >= 100) timeout("mid_edge3");
        rst_n = 1'b0;
        #1;
        check("mid_ready_in_rst", din_ready, 0);
        tick(1);
        check("mid_sclk", sclk, 1);
        check("mid_sdata", sdata, 0);
        check("mid_edge", edge_cnt, 0);
        check("mid_busy", busy, 0);
        check("mid_done", word_done, 0);
        tick(1);
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready", din_ready, 1);
        sb_q.delete();
        check("mid_no_done", done_cnt - d0, 0);
        send_start(8'h3C, 0);
        wait_idle();
        check("mid_new_edge", edge_cnt, 8);
        check("mid_new_done", done_cnt - d0, 1);

        // Fast instance: SCLK toggles every CLK, 16-cycle word, no gap
        rst6   = 1'b1;
        din6   = 8'hC3;
        valid6 = 1'b1;
        #1;
        check("f_ready0", ready6, 1);
        tick(1);
        valid6 = 1'b0;
        w6 = 8'd0;
        for (int c = 0; c < 16; c++) begin
            check($sformatf("f_c%0d_sclk", c), sclk6, c % 2);
            check($sformatf("f_c%0d_ready", c), ready6, 0);
            if (sclk6) w6 = {w6[6:0], sdata6};
            tick(1);
        end
        check("f_c16_done", done6, 1);
        check("f_c16_ready", ready6, 1);
        check("f_c16_sclk", sclk6, 1);
        check("f_edge", edge6, 8);
        check("f_word", w6, 8'hC3);
        tick(1);
        check("f_c17_done", done6, 0);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
